instr_fetch: RTL and testbench

Instruction fetch stage of the single-cycle MIPS-subset CPU, directly upstream of `control`. Holds the program counter, fetches a 32-bit word from instruction memory over a req/ready handshake, and presents the decoded fields (`op`, `fun`, register indices, `imm16`) to control and the datapath. It computes the next PC from control's `nPC_sel` when the rest of the core signals `advance`.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/instr_fetch_if.sv | 10 +
 rtl/npc_logic.sv | 16 +
 rtl/instr_fetch.sv | 74 +++++++
 tb/tb_instr_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset core: fetch FSM states, instruction
// field positions and the opcodes that fetch and control both need.
package cpu_pkg;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_t;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int FUN_MSB = 5;
  localparam int FUN_LSB = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Branch displacement in bytes: sign-extended word offset shifted left by two.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Request/ready bus between the fetch stage (master) and instruction memory (slave).
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/npc_logic.sv
// Combinational next-PC: sequential PC+4 or PC+4 plus the branch displacement.
module npc_logic
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  input  logic        nPC_sel,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;

  assign seq_pc  = pc + 32'd4;
  assign next_pc = nPC_sel ? (seq_pc + branch_offset(imm16)) : seq_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over
// the imem bus, holds it for decode, and commits the next PC on advance.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
)(
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master imem,
  input  logic          advance,
  input  logic          nPC_sel,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [31:0]   pc,
  output logic [5:0]    op,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [5:0]    fun,
  output logic [15:0]   imm16
);

  if_state_t   state;
  logic [31:0] next_pc;

  npc_logic u_npc (
    .pc      (pc),
    .imm16   (imm16),
    .nPC_sel (nPC_sel),
    .next_pc (next_pc)
  );

  // Request is decoded from the state register only, so imem_ready never
  // reaches imem_req/imem_addr combinationally.
  assign imem.imem_req  = (state == IF_FETCH);
  assign imem.imem_addr = pc;

  assign op    = instr[OP_MSB:OP_LSB];
  assign rs    = instr[RS_MSB:RS_LSB];
  assign rt    = instr[RT_MSB:RT_LSB];
  assign rd    = instr[RD_MSB:RD_LSB];
  assign fun   = instr[FUN_MSB:FUN_LSB];
  assign imm16 = instr[IMM_MSB:IMM_LSB];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IF_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IF_IDLE: state <= IF_FETCH;
        IF_FETCH: begin
          if (imem.imem_ready) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            state       <= IF_HOLD;
          end
        end
        IF_HOLD: begin
          if (advance) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            state       <= IF_FETCH;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: acts as instruction memory and checks the fetch
// stage against a PC/field model derived from the branch arithmetic.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] MAIN_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFFC;

  logic        clk;
  logic        reset;
  logic        advance;
  logic        nPC_sel;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  fun;
  logic [15:0] imm16;

  logic        w_reset;
  logic        w_advance;
  logic        w_sel;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_fun;
  logic [15:0] w_imm16;

  int          compared;
  int          mismatched;
  logic [31:0] model_pc;

  instr_fetch_if bus ();
  instr_fetch_if wrap_bus ();

  instr_fetch #(.RESET_PC(MAIN_RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (bus.master),
    .advance     (advance),
    .nPC_sel     (nPC_sel),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .fun         (fun),
    .imm16       (imm16)
  );

  instr_fetch #(.RESET_PC(WRAP_RESET_PC)) dut_wrap (
    .clk         (clk),
    .reset       (w_reset),
    .imem        (wrap_bus.master),
    .advance     (w_advance),
    .nPC_sel     (w_sel),
    .instr_valid (w_valid),
    .instr       (w_instr),
    .pc          (w_pc),
    .op          (w_op),
    .rs          (w_rs),
    .rt          (w_rt),
    .rd          (w_rd),
    .fun         (w_fun),
    .imm16       (w_imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural next-PC rule written as signed integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic sel);
    longint disp;
    disp = sel ? longint'($signed(word[15:0])) * 4 : 0;
    return 32'(longint'(cur) + 4 + disp);
  endfunction

  // Entered at a falling edge with the DUT in FETCH; leaves it in FETCH at the next PC.
  task automatic do_instr(input logic [31:0] word, input int waits, input logic sel);
    int hold;
    hold = $urandom_range(0, 2);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      compared++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== model_pc || instr_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL wait_stall: req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
                 bus.imem_req, bus.imem_addr, instr_valid, model_pc);
      end
      @(negedge clk);
    end
    compared++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== model_pc) begin
      mismatched++;
      $display("[TB] FAIL fetch_req: req=%b addr=%h required req=1 addr=%h",
               bus.imem_req, bus.imem_addr, model_pc);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    bus.imem_rdata = $urandom;
    compared++;
    if (instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || instr !== word || pc !== model_pc) begin
      mismatched++;
      $display("[TB] FAIL fetch_done: valid=%b req=%b instr=%h pc=%h required valid=1 req=0 instr=%h pc=%h",
               instr_valid, bus.imem_req, instr, pc, word, model_pc);
    end
    compared++;
    if (op !== 6'(word >> 26) || rs !== 5'(word >> 21) || rt !== 5'(word >> 16) ||
        rd !== 5'(word >> 11) || fun !== 6'(word) || imm16 !== 16'(word)) begin
      mismatched++;
      $display("[TB] FAIL fields: op=%h rs=%h rt=%h rd=%h fun=%h imm=%h for instr %h",
               op, rs, rt, rd, fun, imm16, word);
    end
    for (int i = 0; i < hold; i++) begin
      advance = 1'b0;
      bus.imem_ready = 1'b1;
      @(negedge clk);
      bus.imem_ready = 1'b0;
      compared++;
      if (instr_valid !== 1'b1 || instr !== word || pc !== model_pc || bus.imem_req !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hold: valid=%b instr=%h pc=%h req=%b required valid=1 instr=%h pc=%h req=0",
                 instr_valid, instr, pc, bus.imem_req, word, model_pc);
      end
    end
    advance = 1'b1;
    nPC_sel = sel;
    @(negedge clk);
    advance  = 1'b0;
    nPC_sel  = 1'($urandom_range(0, 1));
    model_pc = model_next(model_pc, word, sel);
    compared++;
    if (pc !== model_pc || instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL advance: pc=%h valid=%b req=%b required pc=%h valid=0 req=1",
               pc, instr_valid, bus.imem_req, model_pc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (pc !== MAIN_RESET_PC || instr !== 32'h0 || instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: pc=%h instr=%h valid=%b req=%b required pc=%h instr=0 valid=0 req=0",
               pc, instr, instr_valid, bus.imem_req, MAIN_RESET_PC);
    end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0000 || instr_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_release: req=%b addr=%h valid=%b required req=1 addr=00400000 valid=0",
               bus.imem_req, bus.imem_addr, instr_valid);
    end
    model_pc = MAIN_RESET_PC;
  endtask

  task automatic test_add();
    do_instr(32'h0000_0020, 0, 1'b0);
    compared++;
    if (instr !== 32'h0000_0020 || pc !== 32'h0040_0004) begin
      mismatched++;
      $display("[TB] FAIL add_commit: instr=%h pc=%h required instr=00000020 pc=00400004", instr, pc);
    end
  endtask

  task automatic test_wait();
    do_instr(32'h014B_4822, 3, 1'b0);
    compared++;
    if (pc !== 32'h0040_0008) begin
      mismatched++;
      $display("[TB] FAIL wait_commit: pc=%h required 00400008", pc);
    end
  endtask

  task automatic test_branch();
    do_instr({OP_BEQ, 5'd1, 5'd2, 16'hFFFF}, 0, 1'b1);
    compared++;
    if (pc !== 32'h0040_0008) begin
      mismatched++;
      $display("[TB] FAIL beq_self: pc=%h required 00400008", pc);
    end
    do_instr(32'h0000_0020, 0, 1'b0);
    do_instr(32'h0000_0020, 1, 1'b0);
    do_instr({OP_BEQ, 5'd3, 5'd4, 16'h0003}, 0, 1'b0);
    compared++;
    if (pc !== 32'h0040_0014) begin
      mismatched++;
      $display("[TB] FAIL beq_not_taken: pc=%h required 00400014", pc);
    end
    do_instr({OP_BEQ, 5'd0, 5'd0, 16'hFFFE}, 0, 1'b1);
    do_instr({OP_BEQ, 5'd3, 5'd4, 16'h0003}, 2, 1'b1);
    compared++;
    if (pc !== 32'h0040_0020) begin
      mismatched++;
      $display("[TB] FAIL beq_taken: pc=%h required 00400020", pc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    advance = 1'b1;
    #2 reset = 1'b1;
    #1;
    compared++;
    if (instr_valid !== 1'b0 || pc !== MAIN_RESET_PC || bus.imem_req !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: valid=%b pc=%h req=%b required valid=0 pc=%h req=0",
               instr_valid, pc, bus.imem_req, MAIN_RESET_PC);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || pc !== MAIN_RESET_PC || instr !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL late_ready: valid=%b req=%b pc=%h instr=%h required valid=0 req=1 pc=%h instr=0",
               instr_valid, bus.imem_req, pc, instr, MAIN_RESET_PC);
    end
    bus.imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (pc !== MAIN_RESET_PC || bus.imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL advance_in_fetch: pc=%h req=%b valid=%b required pc=%h req=1 valid=0",
               pc, bus.imem_req, instr_valid, MAIN_RESET_PC);
    end
    advance  = 1'b0;
    model_pc = MAIN_RESET_PC;
    do_instr(32'h0000_0020, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] word;
    for (int n = 0; n < 24; n++) begin
      word = $urandom;
      if ($urandom_range(0, 1) == 1) word[31:26] = OP_BEQ;
      do_instr(word, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    compared++;
    if (w_pc !== WRAP_RESET_PC || w_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wrap_reset: pc=%h valid=%b required pc=%h valid=0", w_pc, w_valid, WRAP_RESET_PC);
    end
    w_reset = 1'b0;
    @(negedge clk);
    wrap_bus.imem_ready = 1'b1;
    wrap_bus.imem_rdata = 32'h0000_0020;
    @(negedge clk);
    wrap_bus.imem_ready = 1'b0;
    w_advance = 1'b1;
    w_sel = 1'b0;
    @(negedge clk);
    w_advance = 1'b0;
    compared++;
    if (w_pc !== 32'h0000_0000 || wrap_bus.imem_req !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wrap_seq: pc=%h req=%b required pc=00000000 req=1", w_pc, wrap_bus.imem_req);
    end
    wrap_bus.imem_ready = 1'b1;
    wrap_bus.imem_rdata = {OP_BEQ, 5'd1, 5'd1, 16'hFFFE};
    @(negedge clk);
    wrap_bus.imem_ready = 1'b0;
    w_advance = 1'b1;
    w_sel = 1'b1;
    @(negedge clk);
    w_advance = 1'b0;
    compared++;
    if (w_pc !== 32'hFFFF_FFFC) begin
      mismatched++;
      $display("[TB] FAIL wrap_branch: pc=%h required fffffffc", w_pc);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    model_pc   = MAIN_RESET_PC;
    reset      = 1'b1;
    advance    = 1'b0;
    nPC_sel    = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    w_reset    = 1'b1;
    w_advance  = 1'b0;
    w_sel      = 1'b0;
    wrap_bus.imem_ready = 1'b0;
    wrap_bus.imem_rdata = 32'h0;

    test_reset();
    test_add();
    test_wait();
    test_branch();
    test_reset_mid_fetch();
    test_random();
    test_wrap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
